uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 15 +
 rtl/uart_tx_arb_rr_select.sv | 38 +++
 rtl/uart_tx_arb.sv | 128 ++++++++++++
 tb/tb_uart_tx_arb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t  : 2-bit arbiter state encoding
//   BUSY_TMO_DEF : default cycles allowed for TX_BUSY to rise after launch
package uart_tx_arb_pkg;

  localparam int unsigned BUSY_TMO_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_select.sv
// Combinational round-robin selector.
//   i_req   : request vector
//   i_ptr   : index where the search starts (wraps to 0)
//   o_gnt_c : one-hot grant (all zero when no request)
//   o_idx_c : index of the granted request
module rr_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_c,
  output logic [IW-1:0] o_idx_c
);

  // Scan N positions starting at i_ptr; first hit wins.
  always_comb begin
    logic          w_found;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_j;
    o_gnt_c = '0;
    o_idx_c = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_j = w_sum[IW-1:0];
      if (!w_found && i_req[w_j]) begin
        w_found      = 1'b1;
        o_gnt_c[w_j] = 1'b1;
        o_idx_c      = w_j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
//   i_clk, i_rst                : clock, synchronous active-high reset
//   i_req_valid/data/par_en/par_typ : per-requester byte and parity config
//   o_req_ready                 : one-hot accept pulse to the granted requester
//   o_tx_p_data/par_en/par_typ  : held frame data to the UART transmitter
//   o_tx_data_valid             : one-cycle launch pulse
//   i_tx_busy                   : transmitter busy
//   o_grant_id                  : owner of the current/last frame
//   o_active                    : frame in flight (launch to end/timeout)
//   o_tmo_err                   : pulse when busy never rose after a launch
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [8*N_REQ-1:0]       i_req_data,
  input  logic [N_REQ-1:0]         i_req_par_en,
  input  logic [N_REQ-1:0]         i_req_par_typ,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [7:0]               o_tx_p_data,
  output logic                     o_tx_data_valid,
  output logic                     o_tx_par_en,
  output logic                     o_tx_par_typ,
  input  logic                     i_tx_busy,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_active,
  output logic                     o_tmo_err
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BUSY_TMO + 1);

  arb_state_t     r_state;
  logic [IW-1:0]  r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [N_REQ-1:0] r_req_ready;
  logic [7:0]     r_tx_data;
  logic           r_par_en;
  logic           r_par_typ;
  logic           r_tx_dv;
  logic [IW-1:0]  r_grant_id;
  logic           r_active;
  logic           r_tmo_err;

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_idx;

  rr_select #(.N(N_REQ), .IW(IW)) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_gnt),
    .o_idx_c (w_idx)
  );

  // Arbiter FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_tx_data   <= '0;
      r_par_en    <= 1'b0;
      r_par_typ   <= 1'b0;
      r_tx_dv     <= 1'b0;
      r_grant_id  <= '0;
      r_active    <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_tx_dv     <= 1'b0;
      r_tmo_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (|i_req_valid && !i_tx_busy) begin
            r_req_ready <= w_gnt;
            r_grant_id  <= w_idx;
            // Pointer holds the index after the winner so the next search starts there.
            r_ptr       <= (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);
            r_tx_data   <= i_req_data[{w_idx, 3'b000} +: 8];
            r_par_en    <= i_req_par_en[w_idx];
            r_par_typ   <= i_req_par_typ[w_idx];
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_tx_dv  <= 1'b1;
          r_active <= 1'b1;
          r_cnt    <= '0;
          r_state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (i_tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_cnt == CW'(BUSY_TMO - 1)) begin
            r_tmo_err <= 1'b1;
            r_active  <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!i_tx_busy) begin
            r_active <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready     = r_req_ready;
  assign o_tx_p_data     = r_tx_data;
  assign o_tx_data_valid = r_tx_dv;
  assign o_tx_par_en     = r_par_en;
  assign o_tx_par_typ    = r_par_typ;
  assign o_grant_id      = r_grant_id;
  assign o_active        = r_active;
  assign o_tmo_err       = r_tmo_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb with a simple UART transmitter busy model.
module tb_uart_tx_arb;

  localparam int unsigned NR  = 4;
  localparam int unsigned TMO = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       pen;
    logic       ptyp;
  } launch_t;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [7:0]    d [NR];
  logic [NR-1:0] pen;
  logic [NR-1:0] ptyp;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic [7:0]    tx_p_data;
  logic          tx_dv;
  logic          tx_pen;
  logic          tx_ptyp;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          active;
  logic          tmo_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_rdy_cyc = -10;
  int last_dv_cyc  = -10;
  int exp_tmo = 0;
  int exp_gnt [$];
  launch_t exp_l [$];

  logic tx_en;
  logic force_busy;
  int   busy_cnt;

  assign req_data = {d[3], d[2], d[1], d[0]};
  assign tx_busy  = force_busy | (busy_cnt != 0);

  uart_tx_arb #(.N_REQ(NR), .BUSY_TMO(TMO)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .i_req_data      (req_data),
    .i_req_par_en    (pen),
    .i_req_par_typ   (ptyp),
    .o_req_ready     (req_ready),
    .o_tx_p_data     (tx_p_data),
    .o_tx_data_valid (tx_dv),
    .o_tx_par_en     (tx_pen),
    .o_tx_par_typ    (tx_ptyp),
    .i_tx_busy       (tx_busy),
    .o_grant_id      (grant_id),
    .o_active        (active),
    .o_tmo_err       (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after a launch and lasts 6 cycles.
  always @(posedge clk) begin
    if (tx_en && tx_dv) busy_cnt <= 6;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  // Monitor: pops expectations whenever the DUT presents a grant, launch or timeout.
  always @(negedge clk) begin
    launch_t e;
    int id;
    cyc++;
    if (req_ready != '0) begin
      checks++;
      if (exp_gnt.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected ready=%b", req_ready);
      end else begin
        id = exp_gnt.pop_front();
        if (req_ready !== NR'(1 << id) || grant_id !== 2'(id)) begin
          errors++;
          $display("FAIL grant ready=%b id=%0d expected ready=%b id=%0d",
                   req_ready, grant_id, NR'(1 << id), id);
        end
      end
      last_rdy_cyc = cyc;
    end
    if (tx_dv) begin
      checks++;
      if (exp_l.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected data=%h", tx_p_data);
      end else begin
        e = exp_l.pop_front();
        if (tx_p_data !== e.data || tx_pen !== e.pen || tx_ptyp !== e.ptyp) begin
          errors++;
          $display("FAIL launch data=%h pen=%b ptyp=%b expected data=%h pen=%b ptyp=%b",
                   tx_p_data, tx_pen, tx_ptyp, e.data, e.pen, e.ptyp);
        end
        checks++;
        if ((^tx_p_data ^ tx_ptyp) !== (^e.data ^ e.ptyp)) begin
          errors++;
          $display("FAIL parity_bit got=%b expected=%b", ^tx_p_data ^ tx_ptyp, ^e.data ^ e.ptyp);
        end
      end
      checks++;
      if (last_rdy_cyc != cyc - 1 || tx_busy !== 1'b0 || active !== 1'b1) begin
        errors++;
        $display("FAIL launch_timing rdy_cyc=%0d dv_cyc=%0d busy=%b active=%b expected rdy_cyc=%0d busy=0 active=1",
                 last_rdy_cyc, cyc, tx_busy, active, cyc - 1);
      end
      last_dv_cyc = cyc;
    end
    if (tmo_err) begin
      checks++;
      if (exp_tmo == 0) begin
        errors++;
        $display("FAIL tmo_unexpected cyc=%0d", cyc);
      end else begin
        exp_tmo--;
        if (cyc - last_dv_cyc != int'(TMO) || active !== 1'b0) begin
          errors++;
          $display("FAIL tmo_timing delay=%0d active=%b expected delay=%0d active=0",
                   cyc - last_dv_cyc, active, TMO);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic expect_grant(input int id);
    launch_t e;
    e.data = d[id];
    e.pen  = pen[id];
    e.ptyp = ptyp[id];
    exp_gnt.push_back(id);
    exp_l.push_back(e);
  endtask

  // Returns at the negedge of the cycle in which requester id sees ready.
  task automatic wait_ready(input int id);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (req_ready[id]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_ready_%0d got=timeout expected=ready", id);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_ready"},  32'(req_ready), 32'h0);
    chk({tag, "_dv"},     32'(tx_dv),     32'h0);
    chk({tag, "_tmo"},    32'(tmo_err),   32'h0);
    chk({tag, "_active"}, 32'(active),    32'h0);
    chk({tag, "_gid"},    32'(grant_id),  32'h0);
    chk({tag, "_data"},   32'(tx_p_data), 32'h0);
    chk({tag, "_pen"},    32'(tx_pen),    32'h0);
    chk({tag, "_ptyp"},   32'(tx_ptyp),   32'h0);
  endtask

  initial begin
    bit got;
    rst = 1'b1; req_valid = '0; pen = '0; ptyp = '0;
    tx_en = 1'b1; force_busy = 1'b0; busy_cnt = 0;
    for (int i = 0; i < int'(NR); i++) d[i] = 8'h00;
    tick(); tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Single requester, even parity.
    tick();
    d[0] = 8'hA5; pen = 4'b0001; ptyp = 4'b0000;
    expect_grant(0);
    req_valid = 4'b0001;
    wait_ready(0);
    tick(); req_valid = '0;
    repeat (20) tick();

    // All requesters held valid: grants rotate 0,1,2,3,0.
    rst = 1'b1; tick(); rst = 1'b0;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    pen = 4'b1010; ptyp = 4'b0110;
    for (int k = 0; k < 5; k++) expect_grant(k % 4);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) wait_ready(k % 4);
    tick(); req_valid = '0;
    repeat (20) tick();

    // Requester 2 changes its byte mid-frame; launched data must hold.
    d[2] = 8'h5A; pen = 4'b0100; ptyp = 4'b0100;
    expect_grant(2);
    req_valid = 4'b0100;
    wait_ready(2);
    tick(); req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (tx_busy && active) got = 1'b1;
    end
    chk("reach_wait_done", 32'(got), 32'h1);
    tick(); d[2] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_data", 32'(tx_p_data), 32'h5A);
      chk("hold_ptyp", 32'(tx_ptyp), 32'h1);
    end
    repeat (20) tick();

    // Busy never rises: timeout, pointer left at the index after the last grant.
    tx_en = 1'b0;
    d[1] = 8'h3C; pen = 4'b0000; ptyp = 4'b0000;
    expect_grant(1);
    exp_tmo++;
    req_valid = 4'b0010;
    wait_ready(1);
    tick(); req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (tmo_err) got = 1'b1;
    end
    chk("tmo_seen", 32'(got), 32'h1);
    tick();
    tx_en = 1'b1;
    d[0] = 8'h01; d[2] = 8'h02; d[3] = 8'h03;
    expect_grant(2);
    req_valid = 4'b1111;
    wait_ready(2);
    tick(); req_valid = '0;
    repeat (20) tick();

    // Reset during WAIT_DONE.
    d[3] = 8'h77; pen = 4'b1000; ptyp = 4'b0000;
    expect_grant(3);
    req_valid = 4'b1000;
    wait_ready(3);
    tick(); req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (tx_busy && active) got = 1'b1;
    end
    chk("reach_wait_done_rst", 32'(got), 32'h1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    chk_reset_vals("midrst");
    @(negedge clk);
    chk("midrst_ready2", 32'(req_ready), 32'h0);
    chk("midrst_dv2",    32'(tx_dv),     32'h0);
    repeat (12) tick();

    // Busy while idle blocks the grant until it drops.
    force_busy = 1'b1;
    tick();
    d[1] = 8'hC3; pen = 4'b0010; ptyp = 4'b0010;
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("busy_no_grant", 32'(req_ready), 32'h0);
    end
    tick();
    expect_grant(1);
    force_busy = 1'b0;
    wait_ready(1);
    tick(); req_valid = '0;
    repeat (30) tick();

    chk("gnt_queue_empty",    32'(exp_gnt.size()), 32'h0);
    chk("launch_queue_empty", 32'(exp_l.size()),   32'h0);
    chk("tmo_pending",        32'(exp_tmo),        32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
